// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SPAWN,
    WAIT_HIT,
    SCORE,
    WIN,
    LOSE
  } state_t;

  localparam logic [1:0] WINLOSE_NONE = 2'b00;
  localparam logic [1:0] WINLOSE_WIN  = 2'b10;
  localparam logic [1:0] WINLOSE_LOSE = 2'b01;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mole_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick mole positions.
module mole_lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: picks targets, times responses, keeps score
// and decides win/lose.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int         WIN_SCORE        = 10,
  parameter int         ROUND_CYCLES     = 50_000_000,
  parameter int         MIN_ROUND_CYCLES = 10_000_000,
  parameter int         SPEEDUP_CYCLES   = 4_000_000,
  parameter int         GAP_CYCLES       = 12_500_000,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] buttonin,
  output logic [7:0] led,
  output logic [2:0] placement,
  output logic [3:0] score,
  output logic [1:0] winlose,
  output logic       inst_loss,
  output logic       busy
);

  localparam int MAX_CYCLES = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] ROUND_LEN   = TW'(ROUND_CYCLES);
  localparam logic [TW-1:0] MIN_LEN     = TW'(MIN_ROUND_CYCLES);
  localparam logic [TW-1:0] SPEEDUP_LEN = TW'(SPEEDUP_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [3:0]    WIN_SCORE_L = 4'(WIN_SCORE);

  state_t        state;
  state_t        state_next;
  logic [7:0]    lfsr;
  logic [7:0]    btn_q;
  logic [7:0]    press;
  logic [TW-1:0] timer;
  logic [TW-1:0] round_len;
  logic [TW-1:0] round_len_fast;
  logic [2:0]    cand;
  logic [3:0]    score_inc;
  logic          unused_lfsr_hi;

  mole_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:3];

  // Only rising edges count, so a held button never scores or loses twice.
  assign press = buttonin & ~btn_q;

  always_comb begin
    cand           = lfsr[2:0];
    score_inc      = score;
    round_len_fast = MIN_LEN;
    if (lfsr[2:0] == placement) begin
      cand = lfsr[2:0] + 3'd1;
    end
    if (score < WIN_SCORE_L) begin
      score_inc = score + 4'd1;
    end
    // Subtract only when the result stays at or above the floor; no wraparound.
    if (round_len > SPEEDUP_LEN && (round_len - SPEEDUP_LEN) >= MIN_LEN) begin
      round_len_fast = round_len - SPEEDUP_LEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_next = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (timer == '0) begin
          state_next = SPAWN;
        end
      end
      SPAWN: begin
        busy       = 1'b1;
        state_next = WAIT_HIT;
      end
      WAIT_HIT: begin
        busy = 1'b1;
        if (press == led) begin
          state_next = SCORE;
        end else if (press != 8'd0) begin
          state_next = LOSE;
        end else if (timer == '0) begin
          state_next = LOSE;
        end
      end
      SCORE: begin
        busy = 1'b1;
        if (score_inc == WIN_SCORE_L) begin
          state_next = WIN;
        end else begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q     <= '0;
      led       <= '0;
      placement <= '0;
      score     <= '0;
      winlose   <= WINLOSE_NONE;
      inst_loss <= 1'b0;
      round_len <= ROUND_LEN;
      timer     <= '0;
    end else begin
      btn_q     <= buttonin;
      inst_loss <= 1'b0;
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            score     <= '0;
            winlose   <= WINLOSE_NONE;
            round_len <= ROUND_LEN;
            timer     <= GAP_LOAD;
          end
        end
        GAP: begin
          if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end
        end
        SPAWN: begin
          placement <= cand;
          led       <= 8'd1 << cand;
          timer     <= round_len - TIMER_ONE;
        end
        WAIT_HIT: begin
          if (state_next == SCORE) begin
            led <= '0;
          end else if (state_next == LOSE) begin
            led       <= '0;
            score     <= '0;
            winlose   <= WINLOSE_LOSE;
            inst_loss <= 1'b1;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end
        SCORE: begin
          score     <= score_inc;
          round_len <= round_len_fast;
          if (score_inc == WIN_SCORE_L) begin
            winlose <= WINLOSE_WIN;
          end else begin
            timer <= GAP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: stimulus queues expected events with
// their cycle stamps, a negedge monitor pops and checks them as they appear.
module tb_mole_round_ctrl;

  localparam int WS  = 3;
  localparam int RC  = 20;
  localparam int MRC = 8;
  localparam int SPD = 4;
  localparam int GC  = 4;

  typedef enum int {EV_SPAWN, EV_SCORE, EV_LOSS, EV_WIN} ev_t;
  typedef struct {
    ev_t kind;
    int  score;
    int  cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] buttonin;
  logic [7:0] led;
  logic [2:0] placement;
  logic [3:0] score;
  logic [1:0] winlose;
  logic       inst_loss;
  logic       busy;

  exp_t exp_q[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  mole_round_ctrl #(
    .WIN_SCORE        (WS),
    .ROUND_CYCLES     (RC),
    .MIN_ROUND_CYCLES (MRC),
    .SPEEDUP_CYCLES   (SPD),
    .GAP_CYCLES       (GC),
    .LFSR_SEED        (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .buttonin  (buttonin),
    .led       (led),
    .placement (placement),
    .score     (score),
    .winlose   (winlose),
    .inst_loss (inst_loss),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic pushExpect(input ev_t kind, input int exp_score, input int cyc);
    exp_t e;
    e.kind  = kind;
    e.score = exp_score;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic popExpect(input ev_t kind, output bit ok, output exp_t e);
    checks++;
    ok = 1'b0;
    e.kind  = kind;
    e.score = 0;
    e.cyc   = 0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s event at cycle %0d: nothing queued", kind.name(), cycle);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("[TB] FAIL event order: got %s expected %s at cycle %0d", kind.name(), e.kind.name(), cycle);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] btn, input logic st);
    buttonin = btn;
    start    = st;
  endtask

  // Monitor: every visible DUT event must match the head of the queue.
  logic [7:0] led_p   = 8'd0;
  logic [3:0] score_p = 4'd0;
  logic [1:0] wl_p    = 2'd0;
  logic [2:0] place_p = 3'd0;

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (reset) begin
      led_p   = 8'd0;
      score_p = 4'd0;
      wl_p    = 2'd0;
      place_p = 3'd0;
    end else begin
      if (led_p == 8'd0 && led != 8'd0) begin
        popExpect(EV_SPAWN, ok, e);
        if (ok) begin
          checkOutput("spawn cycle", cycle, e.cyc);
          checkOutput("spawn score", score, e.score);
        end
        checkOutput("spawn winlose", winlose, 2'b00);
        checkOutput("led one-hot", $onehot(led), 1);
        checkOutput("led vs placement", led, 8'd1 << placement);
        checkOutput("placement repeated", placement == place_p, 0);
        place_p = placement;
      end
      if (score > score_p) begin
        popExpect(EV_SCORE, ok, e);
        if (ok) begin
          checkOutput("score cycle", cycle, e.cyc);
          checkOutput("score value", score, e.score);
        end
        checkOutput("led after hit", led, 0);
      end
      if (inst_loss) begin
        popExpect(EV_LOSS, ok, e);
        if (ok) begin
          checkOutput("loss cycle", cycle, e.cyc);
        end
        checkOutput("loss winlose", winlose, 2'b01);
        checkOutput("loss score", score, 0);
        checkOutput("loss led", led, 0);
        checkOutput("loss busy", busy, 0);
      end
      if (winlose == 2'b10 && wl_p != 2'b10) begin
        popExpect(EV_WIN, ok, e);
        if (ok) begin
          checkOutput("win cycle", cycle, e.cyc);
        end
        checkOutput("win score", score, WS);
        checkOutput("win led", led, 0);
        checkOutput("win busy", busy, 0);
      end
      led_p   = led;
      score_p = score;
      wl_p    = winlose;
    end
  end

  task automatic startGame(input bit hold);
    int s;
    s = cycle;
    pushExpect(EV_SPAWN, 0, s + 6);
    applyStimulus(8'h00, 1'b1);
    tick();
    if (!hold) applyStimulus(8'h00, 1'b0);
    checkOutput("busy after start", busy, 1);
    checkOutput("score after start", score, 0);
    checkOutput("winlose after start", winlose, 2'b00);
    checkOutput("led in gap", led, 0);
  endtask

  task automatic waitLed(output int c0);
    for (int i = 0; i < 60 && led == 8'd0; i++) tick();
    checkOutput("spawn within budget", led != 8'd0, 1);
    c0 = cycle;
  endtask

  task automatic pressTarget(input int exp_score);
    int p;
    p = cycle;
    pushExpect(EV_SCORE, exp_score, p + 2);
    if (exp_score == WS) begin
      pushExpect(EV_WIN, WS, p + 2);
      if (start) pushExpect(EV_SPAWN, 0, p + 8);
    end else begin
      pushExpect(EV_SPAWN, exp_score, p + 7);
    end
    applyStimulus(led, start);
    tick();
    applyStimulus(8'h00, start);
  endtask

  task automatic playHit(input int k, input int exp_score);
    int c0;
    waitLed(c0);
    repeat (k) tick();
    pressTarget(exp_score);
  endtask

  task automatic playTimeout(input int len);
    int c0;
    waitLed(c0);
    pushExpect(EV_LOSS, 0, c0 + len);
  endtask

  task automatic playWrong(input bit with_target);
    int         c0;
    logic [7:0] wrong;
    waitLed(c0);
    repeat (2) tick();
    wrong = {led[6:0], led[7]};
    if (with_target) wrong = wrong | led;
    pushExpect(EV_LOSS, 0, cycle + 1);
    applyStimulus(wrong, start);
    tick();
    applyStimulus(8'h00, start);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    checkOutput("expected events seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset led", led, 0);
    checkOutput("reset placement", placement, 0);
    checkOutput("reset score", score, 0);
    checkOutput("reset winlose", winlose, 2'b00);
    checkOutput("reset inst_loss", inst_loss, 0);
    checkOutput("reset busy", busy, 0);

    $display("[TB] three quick hits to a win");
    startGame(1'b0);
    playHit(3, 1);
    playHit(3, 2);
    playHit(3, 3);
    drain();

    $display("[TB] hits on the last cycle of windows 20, 16, 12");
    startGame(1'b0);
    playHit(RC - 1, 1);
    playHit(RC - SPD - 1, 2);
    playHit(RC - 2 * SPD - 1, 3);
    drain();

    $display("[TB] timeout in the shortened second window");
    startGame(1'b0);
    playHit(3, 1);
    playTimeout(RC - SPD);
    drain();

    $display("[TB] timeout in the first window");
    startGame(1'b0);
    playTimeout(RC);
    drain();

    $display("[TB] wrong button");
    startGame(1'b0);
    playWrong(1'b0);
    drain();

    $display("[TB] target plus another button together");
    startGame(1'b0);
    playHit(2, 1);
    playWrong(1'b1);
    drain();

    $display("[TB] buttons held from the gap do not count");
    startGame(1'b0);
    tick();
    applyStimulus(8'hFF, 1'b0);
    waitLed(c0);
    repeat (4) tick();
    applyStimulus(8'h00, 1'b0);
    tick();
    pressTarget(1);
    playHit(3, 2);
    playHit(3, 3);
    drain();

    $display("[TB] start held across the game end");
    startGame(1'b1);
    playHit(1, 1);
    playHit(1, 2);
    playHit(1, 3);
    repeat (3) tick();
    applyStimulus(8'h00, 1'b0);
    playHit(RC - 1, 1);
    playHit(2, 2);
    playHit(2, 3);
    drain();

    $display("[TB] reset in the middle of a round");
    startGame(1'b0);
    playHit(3, 1);
    playHit(3, 2);
    waitLed(c0);
    checkOutput("score before reset", score, 2);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("mid reset score", score, 0);
    checkOutput("mid reset led", led, 0);
    checkOutput("mid reset winlose", winlose, 2'b00);
    checkOutput("mid reset inst_loss", inst_loss, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset placement", placement, 0);
    reset = 1'b0;
    tick();
    checkOutput("no loss pulse after reset", inst_loss, 0);
    checkOutput("idle after reset", busy, 0);
    drain();

    $display("[TB] long run of spawns");
    for (int g = 0; g < 334; g++) begin
      startGame(1'b0);
      playHit(g % 4, 1);
      playHit((g + 1) % 4, 2);
      playHit((g + 2) % 4, 3);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
